// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM input-capture peripheral: register map,
// STATUS bit positions, capture FSM encoding and the duty-cycle ceiling.
package pwm_capture_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_VALID    = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_NOSIG    = 2;
  localparam int STAT_LEVEL    = 3;

  localparam logic [6:0] DUTY_MAX = 7'd100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DIVIDE = 2'd2
  } state_t;

  // Clamp a raw quotient to the 0..100 percent scale.
  function automatic logic [6:0] clamp_duty(input logic [31:0] q);
    return (q > 32'(DUTY_MAX)) ? DUTY_MAX : q[6:0];
  endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// Iterative restoring unsigned divider: one quotient bit per clock after a
// one-clock load. done pulses once; quo holds until the next start.
module pwm_capture_div #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] den_reg;
  logic [DEN_W-1:0] rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic [DEN_W:0]   shifted;
  logic [DEN_W-1:0] diff;
  logic             q_bit;

  // The remainder stays below den, so the low DEN_W bits of the difference suffice.
  assign shifted = {rem_reg, quo[NUM_W-1]};
  assign q_bit   = (shifted >= {1'b0, den_reg});
  assign diff    = shifted[DEN_W-1:0] - den_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      den_reg <= '0;
      rem_reg <= '0;
      cnt_reg <= '0;
      quo     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        den_reg <= den;
        rem_reg <= '0;
        quo     <= num;
        cnt_reg <= CW'(NUM_W);
        busy    <= 1'b1;
      end else if (busy) begin
        rem_reg <= q_bit ? diff : shifted[DEN_W-1:0];
        quo     <= {quo[NUM_W-2:0], q_bit};
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time in prescaled ticks of a
// synchronized input and publishes the duty cycle as an integer percent.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int F_DIV   = 1333,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  input  logic [1:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD
);

  localparam int NUM_W = CNT_W + 7;
  localparam int PW    = (F_DIV < 1) ? 1 : $clog2(F_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       sync_reg;
  logic             level_d_reg;
  logic             level, rise, fall, tick;
  logic             enable_reg, valid_reg, overflow_reg, nosig_reg;
  logic [6:0]       duty_reg;
  logic [CNT_W-1:0] period_reg, high_reg;
  logic [CNT_W-1:0] period_cnt_reg, high_cnt_reg, to_cnt_reg;
  logic             frozen_reg;
  logic [PW-1:0]    presc_reg;
  state_t           state_reg;
  logic             div_start_reg, div_done;
  logic [NUM_W-1:0] div_num, div_quo;
  logic             unused_div_busy;
  logic             unused_wd;
  logic [31:0]      period_word;

  assign level     = sync_reg[1];
  assign rise      = level & ~level_d_reg;
  assign fall      = ~level & level_d_reg;
  assign tick      = enable_reg && (presc_reg == PW'(F_DIV));
  assign div_num   = NUM_W'(high_reg) * NUM_W'(100);
  assign unused_wd = ^WD[31:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      level_d_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], pwm_in};
      level_d_reg <= sync_reg[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_reg     <= 1'b0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      nosig_reg      <= 1'b0;
      duty_reg       <= '0;
      period_reg     <= '0;
      high_reg       <= '0;
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
      to_cnt_reg     <= '0;
      frozen_reg     <= 1'b0;
      presc_reg      <= '0;
      state_reg      <= S_IDLE;
      div_start_reg  <= 1'b0;
    end else begin
      div_start_reg <= 1'b0;
      if (WE && A == ADDR_CTRL) begin
        enable_reg <= WD[0];
        if (WD[1]) overflow_reg <= 1'b0;
      end
      if (!enable_reg) begin
        presc_reg <= '0;
        state_reg <= S_IDLE;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if (state_reg == S_IDLE) begin
          if (rise) begin
            state_reg      <= S_ARMED;
            period_cnt_reg <= CNT_W'(tick);
            high_cnt_reg   <= CNT_W'(tick);
            to_cnt_reg     <= '0;
            frozen_reg     <= 1'b0;
            nosig_reg      <= 1'b0;
          end
        end else begin
          // A tick on the rising-edge cycle belongs to the new (high) cycle.
          if (rise) begin
            period_cnt_reg <= CNT_W'(tick);
            high_cnt_reg   <= CNT_W'(tick);
            to_cnt_reg     <= '0;
            frozen_reg     <= 1'b0;
            if (state_reg == S_ARMED) begin
              period_reg <= period_cnt_reg;
              high_reg   <= high_cnt_reg;
              if (period_cnt_reg == '0) begin
                overflow_reg <= 1'b1;
              end else begin
                div_start_reg <= 1'b1;
                state_reg     <= S_DIVIDE;
              end
            end
          end else begin
            if (fall) begin
              frozen_reg <= 1'b1;
              to_cnt_reg <= '0;
            end
            if (tick) begin
              if (period_cnt_reg != CNT_MAX) period_cnt_reg <= period_cnt_reg + 1'b1;
              if (period_cnt_reg == CNT_MAX - 1'b1) overflow_reg <= 1'b1;
              if (level && !frozen_reg && high_cnt_reg != CNT_MAX)
                high_cnt_reg <= high_cnt_reg + 1'b1;
              if (!fall) to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end
          if (state_reg == S_DIVIDE && div_done) begin
            duty_reg  <= clamp_duty(32'(div_quo));
            valid_reg <= 1'b1;
            state_reg <= S_ARMED;
          end
          // Loss of signal overrides any result finishing in the same cycle.
          if (tick && !rise && !fall && to_cnt_reg == TO_LAST) begin
            nosig_reg <= 1'b1;
            valid_reg <= 1'b0;
            duty_reg  <= level ? DUTY_MAX : 7'd0;
            state_reg <= S_IDLE;
          end
        end
      end
    end
  end

  pwm_capture_div #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(div_start_reg),
    .num  (div_num),
    .den  (period_reg),
    .busy (unused_div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  generate
    if (CNT_W <= 16) begin : g_pack_high
      always_comb begin
        period_word               = '0;
        period_word[CNT_W-1:0]    = period_reg;
        period_word[16 +: CNT_W]  = high_reg;
      end
    end else begin : g_period_only
      always_comb begin
        period_word = 32'(period_reg);
      end
    end
  endgenerate

  always_comb begin
    RD = '0;
    case (A)
      ADDR_CTRL:   RD[0]   = enable_reg;
      ADDR_DUTY:   RD[6:0] = duty_reg;
      ADDR_PERIOD: RD      = period_word;
      default: begin
        RD[STAT_VALID]    = valid_reg;
        RD[STAT_OVERFLOW] = overflow_reg;
        RD[STAT_NOSIG]    = nosig_reg;
        RD[STAT_LEVEL]    = level;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: three instances with different prescale/width/timeout
// settings, pattern generators on their inputs, and a queued read scoreboard.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] rd_a, rd_b, rd_c;

  int   gen_run [3];
  int   gen_hi  [3];
  int   gen_per [3];
  logic gen_lvl [3];

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_req = 1'b0;

  always #5 clk = ~clk;

  // Per-channel PWM source: free-running pattern or a directly held level.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gen
      logic line;
      initial begin : gen_proc
        int ph;
        line = 1'b0;
        ph = 0;
        forever begin
          @(posedge clk);
          #2;
          if (gen_run[gi] != 0) begin
            line = (ph < gen_hi[gi]);
            ph = (ph + 1 >= gen_per[gi]) ? 0 : ph + 1;
          end else begin
            line = gen_lvl[gi];
            ph = 0;
          end
        end
      end
    end
  endgenerate

  pwm_capture #(.F_DIV(1), .CNT_W(8), .TIMEOUT(255)) u_a (
    .clk(clk), .rst_n(rst_n), .pwm_in(g_gen[0].line),
    .A(A), .WD(WD), .WE(WE), .RD(rd_a)
  );

  pwm_capture #(.F_DIV(1), .CNT_W(16), .TIMEOUT(50)) u_b (
    .clk(clk), .rst_n(rst_n), .pwm_in(g_gen[1].line),
    .A(A), .WD(WD), .WE(WE), .RD(rd_b)
  );

  pwm_capture #(.F_DIV(0), .CNT_W(16), .TIMEOUT(65535)) u_c (
    .clk(clk), .rst_n(rst_n), .pwm_in(g_gen[2].line),
    .A(A), .WD(WD), .WE(WE), .RD(rd_c)
  );

  function automatic logic [31:0] rd_of(input int sel);
    case (sel)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  // Monitor: each presented read is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_req) begin
      exp_t        e;
      logic [31:0] got;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        got = rd_of(e.sel) & e.mask;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h required 0x%08h", e.name, got, e.exp);
        end else begin
          $display("ok   %s: 0x%08h", e.name, got);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input int sel, input logic [1:0] addr, input logic [31:0] mask,
                          input logic [31:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    A = addr;
    e.name = name;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    sb_q.push_back(e);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    @(posedge clk);
    #1;
    A  = ADDR_CTRL;
    WD = v;
    WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    $display("wr   CTRL <= 0x%08h", v);
  endtask

  task automatic wait_status(input int sel, input logic [31:0] mask, input logic [31:0] want,
                             input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #1;
      A = ADDR_STATUS;
      #1;
      if ((rd_of(sel) & mask) == want) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: status 0x%08h never reached 0x%08h within %0d clocks",
               name, rd_of(sel) & mask, want, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    A  = 2'd0;
    WD = 32'd0;
    WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gen_run[i] = 0;
      gen_hi[i]  = 0;
      gen_per[i] = 1;
      gen_lvl[i] = 1'b0;
    end
    wait_clk(3);
    rst_n = 1'b1;

    // Reset state
    rd_check(0, ADDR_CTRL,   32'hFFFF_FFFF, 32'h0, "rst_ctrl");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'h0, "rst_duty");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0, "rst_period");
    rd_check(0, ADDR_STATUS, 32'hFFFF_FFFF, 32'h0, "rst_status");
    ctrl_write(32'h1);
    rd_check(0, ADDR_CTRL, 32'hFFFF_FFFF, 32'h1, "ctrl_enable");

    // 100-tick period, 25 ticks high (2 clocks per tick)
    gen_hi[0] = 50; gen_per[0] = 200; gen_run[0] = 1;
    wait_status(0, 32'h1, 32'h1, 1000, "a_wait_valid");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'd25,        "a_duty_25");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0019_0064, "a_period100_high25");
    rd_check(0, ADDR_STATUS, 32'h7,         32'h1,         "a_status_valid");

    // 50 percent
    gen_hi[0] = 100;
    wait_clk(700);
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'd50,        "a_duty_50");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0032_0064, "a_period100_high50");

    // 300-tick period saturates the 8-bit counter: 150*100/255 = 58
    gen_hi[0] = 300; gen_per[0] = 600;
    wait_clk(2000);
    rd_check(0, ADDR_STATUS, 32'h7,         32'h3,         "a_overflow_set");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0096_00FF, "a_period_saturated");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'd58,        "a_duty_saturated");

    // Stop the line low: no-signal with DUTY forced to 0
    gen_run[0] = 0; gen_lvl[0] = 1'b0;
    wait_clk(800);
    rd_check(0, ADDR_STATUS, 32'hF,         32'h6,         "a_nosig_low");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'd0,         "a_duty_forced_0");
    ctrl_write(32'h3);
    rd_check(0, ADDR_STATUS, 32'h2,         32'h0,         "a_overflow_cleared");
    rd_check(0, ADDR_CTRL,   32'hFFFF_FFFF, 32'h1,         "a_enable_kept");

    // Rising edges 5 clocks apart, one tick per clock: second capture dropped
    gen_lvl[2] = 1'b1; wait_clk(10);
    gen_lvl[2] = 1'b0; wait_clk(30);
    gen_lvl[2] = 1'b1; wait_clk(2);
    gen_lvl[2] = 1'b0; wait_clk(3);
    gen_lvl[2] = 1'b1;
    wait_status(2, 32'h1, 32'h1, 200, "c_wait_valid");
    rd_check(2, ADDR_DUTY,   32'hFFFF_FFFF, 32'd25,        "c_duty_first_capture");
    rd_check(2, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h000A_0028, "c_period40_high10");
    rd_check(2, ADDR_STATUS, 32'h7,         32'h1,         "c_no_flag_on_drop");

    // TIMEOUT=50: 50 percent, then held high, back to activity, then held low
    gen_hi[1] = 40; gen_per[1] = 80; gen_run[1] = 1;
    wait_status(1, 32'h1, 32'h1, 1000, "b_wait_valid");
    rd_check(1, ADDR_DUTY,   32'hFFFF_FFFF, 32'd50,  "b_duty_50");
    gen_hi[1] = 80;
    wait_clk(250);
    rd_check(1, ADDR_STATUS, 32'hF,         32'hC,   "b_nosig_high");
    rd_check(1, ADDR_DUTY,   32'hFFFF_FFFF, 32'd100, "b_duty_forced_100");
    gen_hi[1] = 40;
    wait_clk(150);
    rd_check(1, ADDR_STATUS, 32'h4,         32'h0,   "b_nosig_cleared");
    gen_hi[1] = 0;
    wait_clk(250);
    rd_check(1, ADDR_STATUS, 32'hF,         32'h4,   "b_nosig_low");
    rd_check(1, ADDR_DUTY,   32'hFFFF_FFFF, 32'd0,   "b_duty_forced_0");

    // Reset asserted while a division is in flight
    gen_lvl[0] = 1'b1; wait_clk(10);
    gen_lvl[0] = 1'b0; wait_clk(30);
    gen_lvl[0] = 1'b1; wait_clk(8);
    rst_n = 1'b0;
    gen_lvl[0] = 1'b0;
    rd_check(0, ADDR_CTRL,   32'hFFFF_FFFF, 32'h0, "rst_mid_ctrl");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'h0, "rst_mid_duty");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0, "rst_mid_period");
    rd_check(0, ADDR_STATUS, 32'hFFFF_FFFF, 32'h0, "rst_mid_status");
    rst_n = 1'b1;
    ctrl_write(32'h1);
    gen_lvl[0] = 1'b1; wait_clk(10);
    gen_lvl[0] = 1'b0; wait_clk(28);
    rd_check(0, ADDR_STATUS, 32'h1, 32'h0, "a_no_valid_after_one_edge");
    gen_lvl[0] = 1'b1;
    wait_status(0, 32'h1, 32'h1, 200, "a_wait_valid_after_reset");
    rd_check(0, ADDR_DUTY,   32'hFFFF_FFFF, 32'd25,        "a_duty_after_reset");
    rd_check(0, ADDR_PERIOD, 32'hFFFF_FFFF, 32'h0005_0014, "a_period20_high5");

    wait_clk(3);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
